// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch -- single-outstanding instruction fetch unit
//
// Issues one fetch request at a time to instruction memory, holds the
// returned instruction word for decode, and exposes its decoded RISC-V fields.
// Control-flow redirects retarget the pc. A response whose request was
// overtaken by a redirect is discarded through a drop flag.
//
// Optional feature macro: IFU_PERF_CNT_EN adds the fetch_cnt/stall_cnt
// performance counters and their ports.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   imem_req_valid (o)   fetch request valid (REQ state)
//   imem_req_ready (i)   instruction memory accepts the request
//   imem_addr      (o)   fetch address, always equal to pc
//   imem_rsp_valid (i)   response valid
//   imem_rdata     (i)   response instruction word
//   id_ready       (i)   decode consumes the held instruction
//   redirect       (i)   control-flow change request
//   next_pc        (i)   redirect target
//   inst_valid     (o)   inst/pc/fields hold a valid instruction (HOLD state)
//   inst, pc       (o)   held instruction word and its pc
//   opcode, func3, func7, rs1, rs2, rd (o)  fields of inst
//   fetch_cnt, stall_cnt (o)  performance counters (IFU_PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [63:0] next_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0] fetch_cnt,
  output logic [63:0] stall_cnt
`endif
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        drop_q, drop_d;
  logic        drop_now;

  // A response in WAIT is stale if an earlier redirect marked it, or if a
  // redirect arrives in the very same cycle.
  assign drop_now = drop_q | redirect;

  // State, pc, held instruction and drop flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    drop_d  = drop_q;
    case (state_q)
      S_REQ: begin
        // imem_addr may move while the request is not yet accepted.
        if (redirect) begin
          pc_d = next_pc;
        end else begin
          pc_d = pc_q;
        end
        if (imem_req_ready) begin
          state_d = S_WAIT;
          // Accepted with the old pc while redirecting: its response is stale.
          drop_d  = redirect;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d   = next_pc;
          drop_d = 1'b1;
        end else begin
          pc_d   = pc_q;
        end
        if (imem_rsp_valid) begin
          if (drop_now) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            inst_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (id_ready) begin
          state_d = S_REQ;
          if (redirect) begin
            pc_d = next_pc;
          end else begin
            pc_d = pc_q + 64'd4;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign inst_valid     = (state_q == S_HOLD);
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign opcode         = inst_q[6:0];
  assign rd             = inst_q[11:7];
  assign func3          = inst_q[14:12];
  assign rs1            = inst_q[19:15];
  assign rs2            = inst_q[24:20];
  assign func7          = inst_q[31:25];

`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetch_cnt_q, stall_cnt_q;

  // Consumed and stalled HOLD cycles; both counters wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 64'd0;
      stall_cnt_q <= 64'd0;
    end else if (state_q == S_HOLD) begin
      if (id_ready) begin
        fetch_cnt_q <= fetch_cnt_q + 64'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q + 64'd1;
      end
    end else begin
      fetch_cnt_q <= fetch_cnt_q;
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        redirect;
  logic [63:0] next_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetch_cnt;
  logic [63:0] stall_cnt;
`endif

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rdata(imem_rdata), .id_ready(id_ready), .redirect(redirect),
    .next_pc(next_pc), .inst_valid(inst_valid), .inst(inst), .pc(pc),
    .opcode(opcode), .func3(func3), .func7(func7), .rs1(rs1), .rs2(rs2), .rd(rd)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rr;
    logic        rsp;
    logic [31:0] rdata;
    logic        idr;
    logic        redir;
    logic [63:0] npc;
    logic        e_rv;
    logic        e_iv;
    logic [63:0] e_addr;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vec[23];

  function automatic vec_t mk(logic rr, logic rsp, logic [31:0] rdata, logic idr,
                              logic redir, logic [63:0] npc, logic e_rv, logic e_iv,
                              logic [63:0] e_addr, logic [31:0] e_inst);
    vec_t v;
    v.rr = rr; v.rsp = rsp; v.rdata = rdata; v.idr = idr; v.redir = redir;
    v.npc = npc; v.e_rv = e_rv; v.e_iv = e_iv; v.e_addr = e_addr; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Checks all outputs against expected transaction-level values.
  task automatic check_out(input string tag, input logic e_rv, input logic e_iv,
                           input logic [63:0] e_addr, input logic [31:0] e_inst);
    logic [31:0] w;
    w = e_inst;
    chk({tag, "_req_valid"}, {63'd0, imem_req_valid}, {63'd0, e_rv});
    chk({tag, "_inst_valid"}, {63'd0, inst_valid}, {63'd0, e_iv});
    chk({tag, "_addr"}, imem_addr, e_addr);
    chk({tag, "_pc"}, pc, e_addr);
    if (e_iv) begin
      chk({tag, "_inst"}, {32'd0, inst}, {32'd0, w});
      chk({tag, "_fields"}, {28'd0, func7, rs2, rs1, func3, rd, opcode},
          {28'd0, w[31:25], w[24:20], w[19:15], w[14:12], w[11:7], w[6:0]});
    end
  endtask

  task automatic drive(input logic rr, input logic rsp, input logic [31:0] rdata,
                       input logic idr, input logic redir, input logic [63:0] npc);
    imem_req_ready = rr; imem_rsp_valid = rsp; imem_rdata = rdata;
    id_ready = idr; redirect = redir; next_pc = npc;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Transaction-level reference model state.
  logic        m_out, m_stale, m_have;
  logic [63:0] m_pc;
  logic [31:0] m_word;
  logic [63:0] m_fetch, m_stall;

  initial begin
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    rst = 1'b1;

    // Directed table: reset, sequential fetch, stall, redirects, back-pressure.
    vec[0]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,         1'b1, 1'b0, RST_PC, 32'h0);
    vec[1]  = mk(1'b0, 1'b1, 32'h00A0_0093, 1'b0, 1'b0, 64'h0,         1'b0, 1'b0, RST_PC, 32'h0);
    vec[2]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 64'h0,         1'b0, 1'b1, RST_PC, 32'h00A0_0093);
    vec[3]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,         1'b1, 1'b0, 64'h8000_0004, 32'h0);
    vec[4]  = mk(1'b0, 1'b1, 32'h0010_0113, 1'b0, 1'b0, 64'h0,         1'b0, 1'b0, 64'h8000_0004, 32'h0);
    vec[5]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 64'h0,         1'b0, 1'b1, 64'h8000_0004, 32'h0010_0113);
    vec[6]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,         1'b1, 1'b0, 64'h8000_0008, 32'h0);
    vec[7]  = mk(1'b0, 1'b1, 32'h0020_81B3, 1'b0, 1'b0, 64'h0,         1'b0, 1'b0, 64'h8000_0008, 32'h0);
    for (int i = 8; i < 13; i++)
      vec[i] = mk(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'h0,       1'b0, 1'b1, 64'h8000_0008, 32'h0020_81B3);
    vec[13] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 64'h8000_0040, 1'b0, 1'b1, 64'h8000_0008, 32'h0020_81B3);
    for (int i = 14; i < 17; i++)
      vec[i] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,         1'b1, 1'b0, 64'h8000_0040, 32'h0);
    vec[17] = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,         1'b1, 1'b0, 64'h8000_0040, 32'h0);
    vec[18] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 64'h8000_0100, 1'b0, 1'b0, 64'h8000_0040, 32'h0);
    vec[19] = mk(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0,         1'b0, 1'b0, 64'h8000_0100, 32'h0);
    vec[20] = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,         1'b1, 1'b0, 64'h8000_0100, 32'h0);
    vec[21] = mk(1'b0, 1'b1, 32'hFE01_0113, 1'b0, 1'b0, 64'h0,         1'b0, 1'b0, 64'h8000_0100, 32'h0);
    vec[22] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 64'h0,         1'b0, 1'b1, 64'h8000_0100, 32'hFE01_0113);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      check_out($sformatf("vec%0d", i), vec[i].e_rv, vec[i].e_iv, vec[i].e_addr, vec[i].e_inst);
      if (i == 2) begin
        chk("rst_scn_opcode", {57'd0, opcode}, 64'd19);
        chk("rst_scn_rd", {59'd0, rd}, 64'd1);
        chk("rst_scn_func3", {61'd0, func3}, 64'd0);
      end
`ifdef IFU_PERF_CNT_EN
      if (i == 13) begin
        chk("stall_cnt", stall_cnt, 64'd5);
        chk("fetch_cnt", fetch_cnt, 64'd2);
      end
`endif
      drive(vec[i].rr, vec[i].rsp, vec[i].rdata, vec[i].idr, vec[i].redir, vec[i].npc);
      step();
    end

    // pc+4 wraps from the top of the address space to zero.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC); step();
    check_out("wrap_req", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0); step();
    drive(1'b0, 1'b1, 32'h1234_5037, 1'b0, 1'b0, 64'h0); step();
    check_out("wrap_hold", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h1234_5037);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); step();
    check_out("wrap_zero", 1'b1, 1'b0, 64'h0, 32'h0);

    // Redirect coinciding with request acceptance: old response dropped.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h0000_1000); step();
    check_out("redir_acc_wait", 1'b0, 1'b0, 64'h0000_1000, 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0073, 1'b0, 1'b0, 64'h0); step();
    check_out("redir_acc_drop", 1'b1, 1'b0, 64'h0000_1000, 32'h0);

    // Reset mid-transaction, then a stale response in REQ.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0); step();
    check_out("pre_rst_wait", 1'b0, 1'b0, 64'h0000_1000, 32'h0);
    #2 rst = 1'b1;
    #1 check_out("async_rst", 1'b1, 1'b0, RST_PC, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'hAAAA_AAAA, 1'b1, 1'b0, 64'h0); step();
    check_out("stale_rsp", 1'b1, 1'b0, RST_PC, 32'h0);

    // Randomized run against the transaction-level model.
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step();
    rst = 1'b0;
    m_out = 1'b0; m_stale = 1'b0; m_have = 1'b0; m_pc = RST_PC; m_word = 32'h0000_0013;
    m_fetch = 64'd0; m_stall = 64'd0;
    for (int c = 0; c < 3000; c++) begin
      logic        rr, rsp, idr, rdr;
      logic [31:0] rdt;
      logic [63:0] np;
      check_out($sformatf("rnd%0d", c), !m_out && !m_have, m_have, m_pc, m_word);
`ifdef IFU_PERF_CNT_EN
      if (c % 100 == 99) begin
        chk("rnd_fetch_cnt", fetch_cnt, m_fetch);
        chk("rnd_stall_cnt", stall_cnt, m_stall);
      end
`endif
      rr  = ($urandom_range(0, 3) != 0);
      rsp = ($urandom_range(0, 2) != 0);
      idr = ($urandom_range(0, 2) != 0);
      rdr = ($urandom_range(0, 6) == 0);
      rdt = $urandom;
      np  = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 9) == 0) np = 64'hFFFF_FFFF_FFFF_FFF8;
      drive(rr, rsp, rdt, idr, rdr, np);
      // Model: a held word waits for decode; otherwise issue or await a fetch.
      if (m_have) begin
        if (idr) begin
          m_fetch = m_fetch + 64'd1;
          m_have  = 1'b0;
          m_pc    = rdr ? np : m_pc + 64'd4;
        end else begin
          m_stall = m_stall + 64'd1;
        end
      end else if (!m_out) begin
        if (rdr) m_pc = np;
        if (rr) begin
          m_out   = 1'b1;
          m_stale = rdr;
        end
      end else begin
        if (rdr) begin
          m_pc    = np;
          m_stale = 1'b1;
        end
        if (rsp) begin
          m_out = 1'b0;
          if (m_stale) m_stale = 1'b0;
          else begin
            m_have = 1'b1;
            m_word = rdt;
          end
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
